// File: rtl/fp_div_issuer.sv
// Front end for the iterative FP divider: one operation outstanding at a time, with the result held for downstream.
// Latency: 1 + issue stall + divider latency + 1 cycles from request accept to rsp_valid.
// Backpressure: req_ready is high only in IDLE. ISSUE waits on div_in_ready with no limit. HOLD waits on rsp_ready. A WAIT that runs too long is aborted with a cancel pulse.
module fp_div_issuer #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 24,
    parameter int TIMEOUT    = 64,
    localparam int TOTAL     = EXP_WIDTH + MANT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TOTAL-1:0] req_a,
    input  logic [TOTAL-1:0] req_b,
    input  logic [2:0]       req_rnd,
    output logic             div_in_valid,
    input  logic             div_in_ready,
    output logic [TOTAL-1:0] div_a,
    output logic [TOTAL-1:0] div_b,
    output logic [2:0]       div_round_mode,
    output logic             div_cancel,
    input  logic             div_out_valid,
    input  logic [TOTAL-1:0] div_out,
    input  logic [4:0]       div_exc,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TOTAL-1:0] rsp_data,
    output logic [4:0]       rsp_exc,
    output logic             rsp_timeout,
    output logic             err_spurious
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    // Canonical quiet NaN: sign 0, exponent all ones, quiet bit set, remaining fraction bits zero
    localparam logic [TOTAL-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-2){1'b0}}};
    localparam logic [4:0] EXC_NV = 5'b10000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic          timeout_hit;

    // A result arriving on the last WAIT cycle takes priority over the abort
    assign timeout_hit = (state == WAIT) && !div_out_valid && (timer == TIMER_LAST);

    // Handshake outputs are decoded from state only, so no input reaches an output combinationally
    assign req_ready    = (state == IDLE);
    assign div_in_valid = (state == ISSUE);
    assign rsp_valid    = (state == HOLD);

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (req_valid)                    state_nxt = ISSUE;
            ISSUE: if (div_in_ready)                 state_nxt = WAIT;
            WAIT:  if (div_out_valid || timeout_hit) state_nxt = HOLD;
            HOLD:  if (rsp_ready)                    state_nxt = IDLE;
            default:                                 state_nxt = IDLE;
        endcase
    end

    // State register. Reset abandons any operation in flight and sends no cancel.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state <= IDLE;
        else        state <= state_nxt;
    end

    // WAIT watchdog: restart when the divider accepts the operands, then count up and saturate
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            timer <= '0;
        end else if (state == ISSUE && div_in_ready) begin
            timer <= '0;
        end else if (state == WAIT && timer != {TW{1'b1}}) begin
            timer <= timer + 1'b1;
        end
    end

    // Operand capture: latched at accept and held through ISSUE until the divider takes them
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            div_a          <= '0;
            div_b          <= '0;
            div_round_mode <= '0;
        end else if (state == IDLE && req_valid) begin
            div_a          <= req_a;
            div_b          <= req_b;
            div_round_mode <= req_rnd;
        end
    end

    // Response capture (real result or watchdog NaN) and the one-cycle cancel pulse
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rsp_data    <= '0;
            rsp_exc     <= '0;
            rsp_timeout <= 1'b0;
            div_cancel  <= 1'b0;
        end else begin
            div_cancel <= timeout_hit;
            if (state == WAIT && div_out_valid) begin
                rsp_data    <= div_out;
                rsp_exc     <= div_exc;
                rsp_timeout <= 1'b0;
            end else if (timeout_hit) begin
                rsp_data    <= QNAN;
                rsp_exc     <= EXC_NV;
                rsp_timeout <= 1'b1;
            end
        end
    end

    // Sticky flag for a divider result that arrives when none is outstanding
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)                               err_spurious <= 1'b0;
        else if (div_out_valid && state != WAIT)  err_spurious <= 1'b1;
    end

endmodule
